flit_injection_scheduler: RTL and testbench



---
 rtl/flit_injection_scheduler.sv | 128 ++++++++++++
 tb/tb_flit_injection_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_injection_scheduler.sv
// Round-robin injection arbiter: accepts one packet from NUM_REQ local sources
// and serialises it MSB-first into FLIT_COUNT tagged flits for the NoC port.
//
// state | meaning
// IDLE  | waiting for any req_valid; grants and latches the winner on ce
// SEND  | presenting flits of the latched packet until the last one transfers
module flit_injection_scheduler #(
  parameter  int NUM_REQ         = 4,
  parameter  int NODE_COUNT      = 8,
  parameter  int PACKET_ID_WIDTH = 5,
  parameter  int PAYLOAD         = 32,
  parameter  int FLIT_PAYLOAD    = 8,
  localparam int NODE_W     = $clog2(NODE_COUNT),
  localparam int ID_W       = PACKET_ID_WIDTH,
  localparam int FLIT_COUNT = (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD,
  localparam int IDX_W      = (FLIT_COUNT > 1) ? $clog2(FLIT_COUNT) : 1,
  localparam int GNT_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int FLIT_W     = 1 + 2*NODE_W + FLIT_PAYLOAD + ID_W + IDX_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*PAYLOAD-1:0]  req_payload,
  input  logic [NUM_REQ*NODE_W-1:0]   req_dest,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        flit_valid,
  input  logic                        flit_ready,
  output logic [GNT_W-1:0]            grant,
  output logic                        busy,
  output logic                        pkt_done
);

  localparam int PAD_W = FLIT_COUNT * FLIT_PAYLOAD;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]          state;
  logic [GNT_W-1:0]    last_grant;
  logic [GNT_W-1:0]    grant_q;
  logic [ID_W-1:0]     id_cnt [NUM_REQ];
  logic [PAYLOAD-1:0]  pay_q;
  logic [NODE_W-1:0]   dest_q;
  logic [ID_W-1:0]     id_q;
  logic [IDX_W-1:0]    idx_q;

  logic [GNT_W-1:0]        win;
  logic [GNT_W-1:0]        cand;
  logic                    found;
  logic                    accept;
  logic                    xfer;
  logic                    last_flit;
  logic [PAD_W-1:0]        padded;
  logic [FLIT_PAYLOAD-1:0] flit_data;
  logic [NODE_W-1:0]       node_start;

  // Search starts one past the previous winner so every source gets a turn.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GNT_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign accept    = (state == IDLE) && ce && found;
  assign xfer      = (state == SEND) && flit_ready && ce;
  assign last_flit = (idx_q == IDX_W'(FLIT_COUNT - 1));

  assign req_ready  = accept ? (NUM_REQ'(1) << win) : '0;
  assign flit_valid = (state == SEND);
  assign busy       = (state == SEND);
  assign pkt_done   = xfer && last_flit;
  assign grant      = grant_q;

  // Left-justify the payload so flit 0 carries the MSBs and the tail is zero-padded.
  assign padded     = PAD_W'(pay_q) << (PAD_W - PAYLOAD);
  assign flit_data  = padded[PAD_W-1 - int'(idx_q)*FLIT_PAYLOAD -: FLIT_PAYLOAD];
  assign node_start = NODE_W'(grant_q);

  assign flit_out = (state == SEND) ?
                    {1'b1, dest_q, flit_data, id_q, node_start, idx_q} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_W'(NUM_REQ - 1);
      grant_q    <= '0;
      pay_q      <= '0;
      dest_q     <= '0;
      id_q       <= '0;
      idx_q      <= '0;
      id_cnt     <= '{default: '0};
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (accept) begin
            pay_q      <= req_payload[int'(win)*PAYLOAD +: PAYLOAD];
            dest_q     <= req_dest[int'(win)*NODE_W +: NODE_W];
            id_q       <= id_cnt[win];
            grant_q    <= win;
            last_grant <= win;
            idx_q      <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            idx_q <= idx_q + 1'b1;
            if (last_flit) begin
              id_cnt[grant_q] <= id_cnt[grant_q] + 1'b1;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_injection_scheduler.sv
// Scoreboard bench for flit_injection_scheduler: a queue-based packet model
// predicts grants and flits; a monitor compares the DUT every cycle.
module tb_flit_injection_scheduler;

  localparam int NR   = 4;
  localparam int NC   = 8;
  localparam int IDW  = 5;
  localparam int PL   = 32;
  localparam int FP   = 8;
  localparam int NW   = 3;
  localparam int FC   = 4;
  localparam int IXW  = 2;
  localparam int GW   = 2;
  localparam int FW   = 1 + 2*NW + FP + IDW + IXW;
  localparam int PPL  = 20;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ce;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*PL-1:0]   req_payload;
  logic [NR*NW-1:0]   req_dest;
  logic [FW-1:0]      flit_out;
  logic               flit_valid;
  logic               flit_ready;
  logic [GW-1:0]      grant;
  logic               busy;
  logic               pkt_done;

  logic               p_ce;
  logic [NR-1:0]      p_valid;
  logic [NR-1:0]      p_ready;
  logic [NR*PPL-1:0]  p_payload;
  logic [NR*NW-1:0]   p_dest;
  logic [FW-1:0]      p_flit;
  logic               p_fv;
  logic               p_fr;
  logic [GW-1:0]      p_grant;
  logic               p_busy;
  logic               p_done;

  flit_injection_scheduler #(.NUM_REQ(NR), .NODE_COUNT(NC), .PACKET_ID_WIDTH(IDW),
                             .PAYLOAD(PL), .FLIT_PAYLOAD(FP)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .req_valid(req_valid), .req_ready(req_ready),
    .req_payload(req_payload), .req_dest(req_dest), .flit_out(flit_out),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .grant(grant), .busy(busy),
    .pkt_done(pkt_done));

  flit_injection_scheduler #(.NUM_REQ(NR), .NODE_COUNT(NC), .PACKET_ID_WIDTH(IDW),
                             .PAYLOAD(PPL), .FLIT_PAYLOAD(FP)) dut_pad (
    .clk(clk), .rst_n(rst_n), .ce(p_ce), .req_valid(p_valid), .req_ready(p_ready),
    .req_payload(p_payload), .req_dest(p_dest), .flit_out(p_flit),
    .flit_valid(p_fv), .flit_ready(p_fr), .grant(p_grant), .busy(p_busy),
    .pkt_done(p_done));

  always #5 clk = ~clk;

  typedef struct { logic [FW-1:0] flit; bit last; } flit_t;
  typedef struct { logic [NR-1:0] rdy; bit bsy; int gnt; bit hs; } cyc_t;

  flit_t exp_q[$];
  cyc_t  cyc_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  bit    m_busy;
  int    m_left;
  int    m_gnt;
  int    m_last;
  int    m_id [NR];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk_raw(int dest, int data, int id, int src, int idx);
    longint v;
    v = 1;
    v = (v << NW)  | longint'(dest);
    v = (v << FP)  | longint'(data);
    v = (v << IDW) | longint'(id);
    v = (v << NW)  | longint'(src);
    v = (v << IXW) | longint'(idx);
    return FW'(v);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_busy = 0;
    m_left = 0;
    m_gnt  = 0;
    m_last = NR - 1;
    foreach (m_id[k]) m_id[k] = 0;
  endtask

  task automatic set_src(input int k, input logic [PL-1:0] p, input int d);
    req_payload[k*PL +: PL] = p;
    req_dest[k*NW +: NW]    = NW'(d);
  endtask

  // One clock of stimulus plus the reference model's view of that clock.
  task automatic cycle(input logic [NR-1:0] v, input bit c, input bit fr, input bit rnd);
    cyc_t            cur;
    int              g;
    longint unsigned pay;
    int              dst;
    int              data;
    flit_t           f;
    @(negedge clk);
    req_valid  = v;
    ce         = c;
    flit_ready = fr;
    if (rnd) begin
      for (int k = 0; k < NR; k++) begin
        set_src(k, PL'($urandom), $urandom_range(0, NC-1));
      end
    end
    cur.rdy = '0;
    cur.bsy = m_busy;
    cur.gnt = m_gnt;
    cur.hs  = m_busy && c && fr;
    if (!m_busy) begin
      if (c && (v != '0)) begin
        g = -1;
        for (int k = 1; k <= NR; k++) begin
          if (g < 0 && v[(m_last + k) % NR]) g = (m_last + k) % NR;
        end
        cur.rdy = NR'(1) << g;
        pay = longint'(req_payload[g*PL +: PL]) << (FC*FP - PL);
        dst = int'(req_dest[g*NW +: NW]);
        for (int i = 0; i < FC; i++) begin
          data   = int'((pay >> ((FC-1-i)*FP)) & ((64'd1 << FP) - 1));
          f.flit = mk_raw(dst, data, m_id[g], g, i);
          f.last = (i == FC-1);
          exp_q.push_back(f);
        end
        m_id[g] = (m_id[g] + 1) % (1 << IDW);
        m_gnt   = g;
        m_last  = g;
        m_busy  = 1;
        m_left  = FC;
      end
    end else if (cur.hs) begin
      m_left--;
      if (m_left == 0) m_busy = 0;
    end
    cyc_q.push_back(cur);
  endtask

  task automatic check_zero_outputs();
    check("rst_flit_out",   flit_out,   0);
    check("rst_flit_valid", flit_valid, 0);
    check("rst_req_ready",  req_ready,  0);
    check("rst_grant",      grant,      0);
    check("rst_busy",       busy,       0);
    check("rst_pkt_done",   pkt_done,   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #4;
    ce        = 1'b0;
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check_zero_outputs();
    model_reset();
    cyc_q.delete();
    @(negedge clk);
    #4;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    cyc_t c;
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        check("req_ready",  req_ready,  c.rdy);
        check("flit_valid", flit_valid, c.bsy);
        check("busy",       busy,       c.bsy);
        if (c.bsy) begin
          check("grant", grant, c.gnt);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL flit_queue: DUT presents flit %0h, model expects none", flit_out);
          end else begin
            check("flit_out", flit_out, exp_q[0].flit);
            check("pkt_done", pkt_done, c.hs && exp_q[0].last);
            if (c.hs) void'(exp_q.pop_front());
          end
        end else begin
          check("pkt_done_idle", pkt_done, 0);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] pdata [3];
    pdata = '{8'hAB, 8'hCD, 8'hE0};

    rst_n       = 1'b0;
    ce          = 1'b0;
    req_valid   = '0;
    flit_ready  = 1'b0;
    req_payload = '0;
    req_dest    = '0;
    p_ce        = 1'b0;
    p_valid     = '0;
    p_payload   = '0;
    p_dest      = '0;
    p_fr        = 1'b0;
    model_reset();
    #3;
    check_zero_outputs();
    @(negedge clk);
    #4;
    rst_n = 1'b1;

    // Round robin with all sources requesting: 0,1,2,3,0,...
    for (int k = 0; k < NR; k++) set_src(k, PL'(32'h1000_0000 * (k + 1) + k), k + 2);
    repeat (5 * FC + 8) cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    repeat (FC + 2) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Single request from source 1
    set_src(1, 32'hA1B2C3D4, 5);
    cycle(4'b0010, 1'b1, 1'b1, 1'b0);
    repeat (FC + 1) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Backpressure on flit 2
    cycle(4'b0010, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // ID wrap on source 2, then source 0 must keep its own count
    set_src(2, 32'h0BAD_F00D, 7);
    repeat (33 * (FC + 1)) cycle(4'b0100, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    cycle(4'b0001, 1'b1, 1'b1, 1'b0);
    repeat (FC + 1) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Clock-enable gating in IDLE and mid-packet
    repeat (3) cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1, 1'b0);
    repeat (FC + 1) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Reset after flit 1, then source 0 wins first
    cycle(4'b1000, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    do_reset();
    cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    repeat (FC + 1) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Randomised traffic
    repeat (3000) begin
      cycle(NR'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), 1'b1);
    end
    repeat (2 * FC + 4) cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    check("flits_outstanding", exp_q.size(), 0);

    // 20-bit payload: three flits, last one zero-padded
    @(negedge clk);
    p_valid          = 4'b0001;
    p_payload[19:0]  = 20'hABCDE;
    p_dest[2:0]      = 3'd3;
    p_ce             = 1'b1;
    p_fr             = 1'b1;
    #1;
    check("pad_req_ready", p_ready, 4'b0001);
    @(negedge clk);
    p_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pad_flit_valid", p_fv, 1);
      check("pad_flit_out",   p_flit, mk_raw(3, int'(pdata[i]), 0, 0, i));
      check("pad_pkt_done",   p_done, (i == 2));
      @(negedge clk);
    end
    #1;
    check("pad_idle_after", p_fv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
